booth4_wallace_mult_pipe: RTL and testbench
===========================================

BOOTH4_WALLACE_MULT_PIPE -- requirements
Module: booth4_wallace_mult_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16: operand width; legal values are even, 8..32.
REQ-002 The block SHALL expose parameter OUT_REG, default 1: 1 = product register stage present; 0 = final adder output drives out_product from the stage-2 register.
REQ-003 sys_clk  input  1  The single clock; all state SHALL change on its rising edge.
REQ-004 sys_rst_n  input  1  The reset SHALL be asynchronous and active-low.
REQ-005 clr  input  1  Synchronous pipeline flush.
REQ-006 in_valid  input  1  Operand pair and mode are valid.
REQ-007 in_ready  output  1  The block can accept an operand pair this cycle.
REQ-008 in_a  input  WIDTH  Multiplicand.
REQ-009 in_b  input  WIDTH  Multiplier (Booth-recoded).
REQ-010 in_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-011 out_valid  output  1  out_product holds a result.
REQ-012 out_ready  input  1  The consumer accepts the result this cycle.
REQ-013 out_product  output  2*WIDTH  Product.

Function
REQ-014 The block SHALL compute out_product equal to the exact product in_a*in_b in 2*WIDTH bits, interpreted per the in_signed value captured with that operand pair.
REQ-015 In unsigned mode, the block SHALL zero-extend both operands to WIDTH+2 bits before radix-4 Booth recoding; in signed mode it SHALL sign-extend them. This gives WIDTH/2+1 partial products.
REQ-016 Partial-product rows SHALL be sign-extended, and negation SHALL use the invert-plus-correction-bit form; no row SHALL require a carry-propagate add before the tree.
REQ-017 Rows SHALL be reduced to two rows by a tree of 4:2 compressors (carry chain within a level) and 3:2 compressors (for leftover rows and low columns), built with generate loops over WIDTH. Bits above column 2*WIDTH-1 SHALL be discarded.
REQ-018 Stage 1 SHALL register the Booth-recoded partial products.
REQ-019 Stage 2 SHALL register the two compressed rows.
REQ-020 Stage 3 (when OUT_REG=1) SHALL register the carry-propagate sum.
REQ-021 Latency from accept (in_valid & in_ready) to out_valid SHALL be 3 cycles when OUT_REG=1 and 2 cycles when OUT_REG=0, absent stalls.
REQ-022 Each stage SHALL hold a valid bit. A stage SHALL load when it is empty or its contents advance in the same cycle.
REQ-023 in_ready SHALL equal !s1_valid | s1_advance; it SHALL be combinational from out_ready through the stages, with no registered skid.
REQ-024 The last stage SHALL advance only on out_valid & out_ready.
REQ-025 When out_ready=0, out_valid and out_product SHALL hold stable, upstream stages SHALL fill, and in_ready SHALL fall only when all stages are full.
REQ-026 The pipeline SHALL sustain a throughput of one product per cycle when out_ready is held at 1.
REQ-027 Results SHALL leave in acceptance order. No result SHALL be dropped or duplicated.
REQ-028 The in_signed value SHALL travel with its operands, so mixed modes in consecutive cycles SHALL be computed correctly.
REQ-029 clr=1 SHALL clear all valid bits on the next edge and force in_ready=0 during the clr cycle. Any input presented in that cycle is not accepted, and clr has priority over all other events.
REQ-030 Data registers SHALL NOT need reset. out_product SHALL read 0 whenever out_valid=0, by gating on the last-stage valid bit.

Reset
REQ-031 While sys_rst_n=0, all valid bits SHALL be 0, out_valid SHALL be 0, out_product SHALL be 0, and in_ready SHALL be 0.
REQ-032 in_ready SHALL rise in the first cycle after sys_rst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight results immediately, asynchronously.
REQ-034 No result from before reset SHALL appear after reset release.

Verification
REQ-035 WIDTH=16, signed, a=0x8000, b=0x8000 -> out_product=0x40000000 three cycles later. Signed a=0xFFFF, b=0x0001 -> 0xFFFFFFFF.
REQ-036 WIDTH=16, unsigned, a=0xFFFF, b=0xFFFF -> 0xFFFE0001. Back-to-back signed a=0xFFFF, b=0xFFFF -> 0x00000001 on the next cycle.
REQ-037 Apply 5 consecutive operand pairs with out_ready=0 from cycle 2 to 6. Required: in_ready=0 once 3 results are held; all 5 products emerge in order; out_product is stable during the stall.
REQ-038 Assert clr with 2 results in flight -> out_valid=0 on the next cycle, and no stale product ever appears. A pair accepted after clr returns its correct product.
REQ-039 Assert sys_rst_n=0 asynchronously between edges with 3 results in flight -> out_valid=0 immediately. After release, the first new result equals its own operand product.
REQ-040 Run 10^5 random operand pairs per WIDTH in {8, 16, 32}, with random in_signed, in_valid and out_ready -> a scoreboard against a behavioural multiply shows zero mismatches and no loss or reordering.

Source files
------------

// File: rtl/booth4_wallace_mult_pipe.sv
// Pipelined radix-4 Booth multiplier with a 4:2/3:2 compressor tree and a valid/ready handshake.
// Stage 1 holds the Booth partial products, stage 2 the two compressed rows, stage 3 (optional) the sum.
module booth4_wallace_mult_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned OUT_REG = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
);
    localparam int unsigned P      = 2 * WIDTH;
    localparam int unsigned XW     = WIDTH + 2;
    localparam int unsigned N_PP   = WIDTH / 2 + 1;
    localparam int unsigned N_ROWS = N_PP + 1;

    // Rows left after one tree level: each group of four gives two, a leftover three gives two.
    function automatic int unsigned next_rows(input int unsigned r);
        return 2 * (r / 4) + (((r % 4) == 3) ? 2 : (r % 4));
    endfunction

    function automatic int unsigned rows_at(input int unsigned r0, input int unsigned lvl);
        int unsigned r = r0;
        for (int unsigned k = 0; k < lvl; k++) begin
            r = next_rows(r);
        end
        return r;
    endfunction

    function automatic int unsigned num_levels(input int unsigned r0);
        int unsigned r = r0;
        int unsigned n = 0;
        while (r > 2) begin
            r = next_rows(r);
            n++;
        end
        return n;
    endfunction

    localparam int unsigned N_LVL = num_levels(N_ROWS);

    logic              run;
    logic              accept;
    logic              s1_valid;
    logic              s2_valid;
    logic              s1_adv;
    logic              s2_adv;

    logic [XW-1:0]     a_ext;
    logic [XW:0]       b_ext;
    logic [P-1:0]      pp_row [N_PP];
    logic [N_PP-1:0]   pp_neg;

    logic [P-1:0]      s1_row [N_PP];
    logic [N_PP-1:0]   s1_neg;
    logic [P-1:0]      corr;
    logic [P-1:0]      row0 [N_ROWS];
    logic [P-1:0]      tree_sum;
    logic [P-1:0]      tree_carry;
    logic [P-1:0]      s2_sum;
    logic [P-1:0]      s2_carry;
    logic [P-1:0]      sum_c;

    // Multiplier carries an implicit zero below bit 0 for the first Booth triplet.
    assign a_ext = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
    assign b_ext = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};

    for (genvar i = 0; i < N_PP; i++) begin : g_booth
        logic [2:0]    trip;
        logic          one;
        logic          two;
        logic [XW-1:0] mag;
        logic [XW-1:0] sel;
        logic [P-1:0]  sx;

        assign trip = b_ext[2*i+2 : 2*i];
        assign one  = trip[1] ^ trip[0];
        assign two  = (trip == 3'b011) | (trip == 3'b100);
        assign mag  = two ? {a_ext[XW-2:0], 1'b0} : (one ? a_ext : '0);
        assign sel  = trip[2] ? ~mag : mag;
        assign sx   = {{(P-XW){sel[XW-1]}}, sel};
        assign pp_row[i] = sx << (2 * i);
        assign pp_neg[i] = trip[2];
    end

    assign accept   = in_valid & in_ready;
    assign s1_adv   = s1_valid & (~s2_valid | s2_adv);
    assign in_ready = run & ~clr & (~s1_valid | s1_adv);

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid <= 1'b1;
            end else if (s2_adv) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            s1_row <= pp_row;
            s1_neg <= pp_neg;
        end
    end

    // Correction bits that complete the two's-complement negation of each inverted row.
    for (genvar j = 0; j < P; j++) begin : g_corr
        if ((j % 2) == 0 && (j / 2) < N_PP) begin : g_bit
            assign corr[j] = s1_neg[j/2];
        end else begin : g_zero
            assign corr[j] = 1'b0;
        end
    end

    for (genvar k = 0; k < N_PP; k++) begin : g_row0
        assign row0[k] = s1_row[k];
    end
    assign row0[N_PP] = corr;

    for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
        localparam int unsigned R  = rows_at(N_ROWS, l);
        localparam int unsigned RN = next_rows(R);
        localparam int unsigned NQ = R / 4;
        localparam int unsigned RM = R % 4;

        logic [P-1:0] cur [R];
        logic [P-1:0] nxt [RN];

        if (l == 0) begin : g_src0
            for (genvar k = 0; k < R; k++) begin : g_cp
                assign cur[k] = row0[k];
            end
        end else begin : g_srcn
            for (genvar k = 0; k < R; k++) begin : g_cp
                assign cur[k] = g_lvl[l-1].nxt[k];
            end
        end

        // 4:2 compressors; the horizontal carry does not depend on the incoming carry.
        for (genvar g = 0; g < NQ; g++) begin : g_c42
            logic [P-1:0] x0, x1, x2, x3, xs, ci, sm;
            logic [P-2:0] co, cy;

            assign x0 = cur[4*g];
            assign x1 = cur[4*g+1];
            assign x2 = cur[4*g+2];
            assign x3 = cur[4*g+3];
            assign xs = x0 ^ x1 ^ x2;
            assign co = (x0[P-2:0] & x1[P-2:0]) | (x0[P-2:0] & x2[P-2:0]) | (x1[P-2:0] & x2[P-2:0]);
            assign ci = {co, 1'b0};
            assign sm = xs ^ x3 ^ ci;
            assign cy = (xs[P-2:0] & x3[P-2:0]) | (xs[P-2:0] & ci[P-2:0]) | (x3[P-2:0] & ci[P-2:0]);
            assign nxt[2*g]   = sm;
            assign nxt[2*g+1] = {cy, 1'b0};
        end

        if (RM == 3) begin : g_c32
            logic [P-1:0] y0, y1, y2;
            logic [P-2:0] cy;

            assign y0 = cur[4*NQ];
            assign y1 = cur[4*NQ+1];
            assign y2 = cur[4*NQ+2];
            assign cy = (y0[P-2:0] & y1[P-2:0]) | (y0[P-2:0] & y2[P-2:0]) | (y1[P-2:0] & y2[P-2:0]);
            assign nxt[2*NQ]   = y0 ^ y1 ^ y2;
            assign nxt[2*NQ+1] = {cy, 1'b0};
        end else begin : g_pass
            for (genvar k = 0; k < RM; k++) begin : g_cp
                assign nxt[2*NQ+k] = cur[4*NQ+k];
            end
        end

        if (l == N_LVL - 1) begin : g_last
            assign tree_sum   = nxt[0];
            assign tree_carry = nxt[1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (s1_adv) begin
            s2_sum   <= tree_sum;
            s2_carry <= tree_carry;
        end
    end

    assign sum_c = s2_sum + s2_carry;

    if (OUT_REG != 0) begin : g_out_reg
        logic         s3_valid;
        logic [P-1:0] s3_prod;

        assign s2_adv = s2_valid & (~s3_valid | out_ready);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                s3_valid <= 1'b0;
            end else if (clr) begin
                s3_valid <= 1'b0;
            end else if (s2_adv) begin
                s3_valid <= 1'b1;
            end else if (out_ready) begin
                s3_valid <= 1'b0;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (s2_adv) begin
                s3_prod <= sum_c;
            end
        end

        assign out_valid   = s3_valid;
        assign out_product = s3_valid ? s3_prod : '0;
    end else begin : g_no_out_reg
        assign s2_adv      = s2_valid & out_ready;
        assign out_valid   = s2_valid;
        assign out_product = s2_valid ? sum_c : '0;
    end

endmodule

// File: tb/tb_booth4_wallace_mult_pipe.sv
// Self-checking bench: directed latency/stall/flush/reset cases plus random traffic against a plain multiply.
module tb_booth4_wallace_mult_pipe;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned OUT_REG = 1;
    localparam int unsigned P       = 2 * WIDTH;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             clr       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a      = '0;
    logic [WIDTH-1:0] in_b      = '0;
    logic             in_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [P-1:0]     out_product;

    int checks   = 0;
    int failures = 0;
    logic [P-1:0] exp_q [$];

    always #5 sys_clk = ~sys_clk;

    booth4_wallace_mult_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

    function automatic logic [P-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        return P'(sa * sb);
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(WIDTH-1){1'b0}}};
            3:       v = {1'b0, {(WIDTH-1){1'b1}}};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_signed = s;
    endtask

    task automatic wait_result(input string tag, input logic [P-1:0] want);
        int n = 0;
        @(negedge sys_clk);
        while (!out_valid && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_seen"}, 64'(out_valid), 64'd1);
        check(tag, 64'(out_product), 64'(want));
        tick();
    endtask

    // Scoreboard: every accepted pair queues its product; every output transfer pops one.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_extra_output", 64'(out_valid), 64'd0);
                else check("sb_product", 64'(out_product), 64'(exp_q.pop_front()));
            end
            if (!out_valid) check("idle_zero", 64'(out_product), 64'd0);
            if (in_valid && in_ready) exp_q.push_back(ref_mul(in_a, in_b, in_signed));
            if (clr) exp_q.delete();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time=%0t limit reached, required finish", $time);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] da [$];
        logic [WIDTH-1:0] db [$];
        logic             ds [$];
        logic [P-1:0]     dexp [$];
        logic [P-1:0]     e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        int               idx;
        bit               acc;
        int               n;

        // Reset values
        repeat (3) tick();
        @(negedge sys_clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_product", 64'(out_product), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        @(negedge sys_clk);
        check("rdy_after_rst", 64'(in_ready), 64'd1);
        tick();

        // Latency and back-to-back corner products
        da   = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        db   = '{16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF};
        ds   = '{1'b1, 1'b1, 1'b0, 1'b1};
        dexp = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'h0000_0001};
        for (int c = 0; c < 8; c++) begin
            if (c < 4) put(1'b1, da[c], db[c], ds[c]);
            else put(1'b0, '0, '0, 1'b0);
            @(negedge sys_clk);
            if (c < 4) check("lat_in_ready", 64'(in_ready), 64'd1);
            check("lat_out_valid", 64'(out_valid), 64'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("lat_product", 64'(out_product), 64'(dexp[c-3]));
            tick();
        end

        // Stall: five pairs with the consumer blocked for cycles 2..6
        da.delete(); db.delete(); ds.delete();
        for (int k = 0; k < 5; k++) begin
            da.push_back(WIDTH'($urandom));
            db.push_back(WIDTH'($urandom));
            ds.push_back(1'($urandom_range(0, 1)));
        end
        e   = ref_mul(da[0], db[0], ds[0]);
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready = (c < 2 || c > 6);
            if (idx < 5) put(1'b1, da[idx], db[idx], ds[idx]);
            else put(1'b0, '0, '0, 1'b0);
            @(negedge sys_clk);
            if (c == 2) check("stall_rdy_open", 64'(in_ready), 64'd1);
            if (c >= 3 && c <= 6) begin
                check("stall_rdy_full", 64'(in_ready), 64'd0);
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_product", 64'(out_product), 64'(e));
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        check("stall_all_accepted", 64'(idx), 64'd5);
        check("stall_all_emerged", 64'(exp_q.size()), 64'd0);

        // Flush with two results in flight
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            clr = (c == 2);
            if (c < 3) put(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            else put(1'b0, '0, '0, 1'b0);
            @(negedge sys_clk);
            if (c == 2) check("clr_in_ready", 64'(in_ready), 64'd0);
            if (c >= 3) begin
                check("clr_no_valid", 64'(out_valid), 64'd0);
                check("clr_zero_product", 64'(out_product), 64'd0);
            end
            tick();
        end
        clr = 1'b0;
        ra = WIDTH'($urandom); rb = WIDTH'($urandom); rs = 1'b1;
        put(1'b1, ra, rb, rs);
        @(negedge sys_clk);
        check("clr_after_ready", 64'(in_ready), 64'd1);
        tick();
        put(1'b0, '0, '0, 1'b0);
        wait_result("clr_after_product", ref_mul(ra, rb, rs));

        // Asynchronous reset with three results in flight
        for (int c = 0; c < 3; c++) begin
            put(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            tick();
        end
        put(1'b0, '0, '0, 1'b0);
        check("arst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_product", 64'(out_product), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        tick();
        ra = WIDTH'($urandom); rb = WIDTH'($urandom); rs = 1'b0;
        put(1'b1, ra, rb, rs);
        tick();
        put(1'b0, '0, '0, 1'b0);
        wait_result("arst_first_product", ref_mul(ra, rb, rs));

        // Random traffic: mixed modes, bursty valid, random backpressure, rare flushes
        for (int c = 0; c < 20000; c++) begin
            clr       = ($urandom_range(0, 499) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            put(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom_range(0, 1)));
            @(negedge sys_clk);
            tick();
        end

        // Drain
        clr       = 1'b0;
        out_ready = 1'b1;
        put(1'b0, '0, '0, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge sys_clk);
            tick();
            n++;
        end
        repeat (4) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
